// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and defaults for the staged reset sequencer.
//   rsq_state_e : sequencer state encoding (HOLD=0, WAIT_LOCK=1, RELEASE=2,
//                 RUN=3), STATE_W bits wide; visible on seq_state.
//   DEF_*       : default parameter values for reset_seq_ctrl.
//   cnt_width   : width of a counter that must be able to hold max_val.
// -----------------------------------------------------------------------------
package reset_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } rsq_state_e;

    localparam int DEF_N_DOM     = 4;
    localparam int DEF_STAGE_DLY = 16;
    localparam int DEF_LOCK_FILT = 8;
    localparam int DEF_SW_HOLD   = 32;
    localparam int DEF_WDOG_CYC  = 65536;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage : reset_seq_pkg

// File: rtl/reset_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// reset_seq_ctrl_if
// Groups the sequencer's lock/request inputs and reset/status outputs.
//   pll_locked   : PLL lock, asynchronous to clk (synchronized inside)
//   sw_rst_req   : single-cycle software reset request, clk domain
//   rst_n_out    : per-domain active-low resets, bit 0 released first
//   seq_done     : high while every domain is released
//   seq_state    : current sequencer state encoding
//   lock_timeout : sticky lock-wait watchdog flag
// Modports: slave = the sequencer, master = the surrounding logic.
// -----------------------------------------------------------------------------
interface reset_seq_ctrl_if
    import reset_seq_pkg::*;
#(
    parameter int N_DOM = DEF_N_DOM
) ();

    logic               pll_locked;
    logic               sw_rst_req;
    logic [N_DOM-1:0]   rst_n_out;
    logic               seq_done;
    logic [STATE_W-1:0] seq_state;
    logic               lock_timeout;

    modport slave (
        input  pll_locked,
        input  sw_rst_req,
        output rst_n_out,
        output seq_done,
        output seq_state,
        output lock_timeout
    );

    modport master (
        output pll_locked,
        output sw_rst_req,
        input  rst_n_out,
        input  seq_done,
        input  seq_state,
        input  lock_timeout
    );

endinterface : reset_seq_ctrl_if

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop single-bit synchronizer with asynchronous active-low clear.
//   clk         : destination clock
//   async_rst_n : asynchronous active-low clear, both flops go to 0
//   i_d         : asynchronous input bit
//   o_q         : synchronized output, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic async_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; r_meta may go metastable and is never used elsewhere.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/reset_seq_ctrl.sv
// -----------------------------------------------------------------------------
// reset_seq_ctrl
// Turns the board reset plus PLL lock into N_DOM staged domain resets.
// After a filtered lock, domains are released one at a time (bit 0 first)
// every STAGE_DLY cycles. Lock loss or a software request drops everything
// back to HOLD. All outputs are registered in the clk domain.
//   clk         : system clock
//   async_rst_n : asynchronous active-low reset
//   ctrl_if     : reset_seq_ctrl_if.slave (pll_locked, sw_rst_req in;
//                 rst_n_out, seq_done, seq_state, lock_timeout out)
// Build option: define RST_SEQ_WDOG_EN to add the lock-wait watchdog that
// sets the sticky lock_timeout flag after WDOG_CYC cycles in WAIT_LOCK;
// otherwise lock_timeout is tied to 0.
// -----------------------------------------------------------------------------
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int N_DOM     = DEF_N_DOM,
    parameter int STAGE_DLY = DEF_STAGE_DLY,
    parameter int LOCK_FILT = DEF_LOCK_FILT,
    parameter int SW_HOLD   = DEF_SW_HOLD,
    parameter int WDOG_CYC  = DEF_WDOG_CYC
) (
    input  logic             clk,
    input  logic             async_rst_n,
    reset_seq_ctrl_if.slave  ctrl_if
);

    localparam int HOLD_W = cnt_width(SW_HOLD);
    localparam int FILT_W = cnt_width(LOCK_FILT);
    localparam int STG_W  = cnt_width(STAGE_DLY);
    localparam int IDX_W  = cnt_width(N_DOM);

    // Terminal counts: each counter stops here and never wraps.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SW_HOLD - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DOM - 1);

    localparam logic [N_DOM-1:0]  DOM_NONE  = {N_DOM{1'b0}};
    localparam logic [N_DOM-1:0]  DOM_ALL   = {N_DOM{1'b1}};
    localparam logic [N_DOM-1:0]  DOM_FIRST = N_DOM'(1'b1);

    logic              w_lock_s;

    rsq_state_e        r_state,    w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic              r_hold_sw,  w_hold_sw_nxt;
    logic [FILT_W-1:0] r_filt_cnt, w_filt_cnt_nxt;
    logic [STG_W-1:0]  r_stg_cnt,  w_stg_cnt_nxt;
    logic [IDX_W-1:0]  r_idx,      w_idx_nxt;
    logic [N_DOM-1:0]  r_rst_n,    w_rst_n_nxt;
    logic              r_seq_done, w_seq_done_nxt;
    logic [N_DOM-1:0]  w_rel_mask;
    logic              r_lock_timeout;

    sync_2ff u_lock_sync (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .i_d         (ctrl_if.pll_locked),
        .o_q         (w_lock_s)
    );

    assign w_rel_mask = DOM_FIRST << r_idx;

    // State and counter registers; async reset lands in HOLD with a zero hold.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= {HOLD_W{1'b0}};
            r_hold_sw  <= 1'b0;
            r_filt_cnt <= {FILT_W{1'b0}};
            r_stg_cnt  <= {STG_W{1'b0}};
            r_idx      <= {IDX_W{1'b0}};
            r_rst_n    <= DOM_NONE;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_hold_sw  <= w_hold_sw_nxt;
            r_filt_cnt <= w_filt_cnt_nxt;
            r_stg_cnt  <= w_stg_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_rst_n    <= w_rst_n_nxt;
            r_seq_done <= w_seq_done_nxt;
        end
    end

    // Next-state and next-output decode: sw request, then lock loss, then progress.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_hold_sw_nxt  = r_hold_sw;
        w_filt_cnt_nxt = {FILT_W{1'b0}};
        w_stg_cnt_nxt  = {STG_W{1'b0}};
        w_idx_nxt      = {IDX_W{1'b0}};
        w_rst_n_nxt    = r_rst_n;
        w_seq_done_nxt = 1'b0;

        if (ctrl_if.sw_rst_req) begin
            // r_hold_sw marks a full SW_HOLD hold; otherwise HOLD lasts one cycle.
            w_state_nxt    = ST_HOLD;
            w_hold_cnt_nxt = {HOLD_W{1'b0}};
            w_hold_sw_nxt  = 1'b1;
            w_rst_n_nxt    = DOM_NONE;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_rst_n_nxt = DOM_NONE;
                    if (!r_hold_sw || (r_hold_cnt == HOLD_LAST)) begin
                        w_state_nxt    = ST_WAIT_LOCK;
                        w_hold_cnt_nxt = {HOLD_W{1'b0}};
                        w_hold_sw_nxt  = 1'b0;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1'b1);
                    end
                end
                ST_WAIT_LOCK: begin
                    w_rst_n_nxt = DOM_NONE;
                    if (w_lock_s) begin
                        if (r_filt_cnt == FILT_LAST) begin
                            w_state_nxt = ST_RELEASE;
                        end else begin
                            w_filt_cnt_nxt = r_filt_cnt + FILT_W'(1'b1);
                        end
                    end else begin
                        w_filt_cnt_nxt = {FILT_W{1'b0}};
                    end
                end
                ST_RELEASE: begin
                    if (!w_lock_s) begin
                        // Lock loss beats a simultaneous final release.
                        w_state_nxt    = ST_HOLD;
                        w_hold_cnt_nxt = {HOLD_W{1'b0}};
                        w_hold_sw_nxt  = 1'b0;
                        w_rst_n_nxt    = DOM_NONE;
                    end else if (r_stg_cnt == STG_LAST) begin
                        w_rst_n_nxt = r_rst_n | w_rel_mask;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt    = ST_RUN;
                            w_seq_done_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1'b1);
                        end
                    end else begin
                        w_stg_cnt_nxt = r_stg_cnt + STG_W'(1'b1);
                        w_idx_nxt     = r_idx;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt    = ST_HOLD;
                        w_hold_cnt_nxt = {HOLD_W{1'b0}};
                        w_hold_sw_nxt  = 1'b0;
                        w_rst_n_nxt    = DOM_NONE;
                    end else begin
                        w_rst_n_nxt    = DOM_ALL;
                        w_seq_done_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = {HOLD_W{1'b0}};
                    w_hold_sw_nxt  = 1'b0;
                    w_rst_n_nxt    = DOM_NONE;
                end
            endcase
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int WDOG_W = cnt_width(WDOG_CYC);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    logic [WDOG_W-1:0] r_wdog_cnt;

    // Lock-wait watchdog: counts WAIT_LOCK cycles, flag is sticky until sw request.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_wdog_cnt     <= {WDOG_W{1'b0}};
            r_lock_timeout <= 1'b0;
        end else if (ctrl_if.sw_rst_req) begin
            r_wdog_cnt     <= {WDOG_W{1'b0}};
            r_lock_timeout <= 1'b0;
        end else if (r_state == ST_WAIT_LOCK) begin
            if (r_wdog_cnt != WDOG_MAX) begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1'b1);
            end else begin
                r_wdog_cnt <= r_wdog_cnt;
            end
            if (r_wdog_cnt == WDOG_LAST) begin
                r_lock_timeout <= 1'b1;
            end else begin
                r_lock_timeout <= r_lock_timeout;
            end
        end else begin
            r_wdog_cnt     <= {WDOG_W{1'b0}};
            r_lock_timeout <= r_lock_timeout;
        end
    end
`else
    logic w_wdog_unused;
    assign w_wdog_unused  = (WDOG_CYC > 0);
    assign r_lock_timeout = 1'b0;
`endif

    assign ctrl_if.rst_n_out    = r_rst_n;
    assign ctrl_if.seq_done     = r_seq_done;
    assign ctrl_if.seq_state    = r_state;
    assign ctrl_if.lock_timeout = r_lock_timeout;

endmodule : reset_seq_ctrl
